reg_readback_port: RTL and testbench



---
 rtl/reg_readback_port.sv | 155 +++++++++++++++
 tb/tb_reg_readback_port.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_readback_port.sv
// CPU-side readback port for the cartridge register bank: a loadable, auto-incrementing
// pointer with a one-entry prefetch buffer that hides the variable source fetch latency.
module reg_readback_port #(
    parameter int WIDTH     = 8,
    parameter int AWIDTH    = 6,
    parameter int DEPTH     = 48,
    parameter int RESET_PTR = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cs,
    input  logic              rw,
    input  logic              addr,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic [AWIDTH-1:0] src_addr,
    output logic              src_rd,
    input  logic              src_ack,
    input  logic [WIDTH-1:0]  src_data,
    output logic              valid,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [AWIDTH-1:0] LAST_PTR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH-1:0] RST_PTR  = AWIDTH'(RESET_PTR);

    state_t              r_state;
    logic [AWIDTH-1:0]   r_ptr;
    logic [WIDTH-1:0]    r_buf;
    logic [WIDTH-1:0]    r_data_out;
    logic [AWIDTH-1:0]   r_src_addr;
    logic                r_src_rd;
    logic                r_drop;

    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0]    w_buf_nxt;
    logic [WIDTH-1:0]    w_data_out_nxt;
    logic [AWIDTH-1:0]   w_src_addr_nxt;
    logic                w_src_rd_nxt;
    logic                w_drop_nxt;

    logic                w_ptr_wr;
    logic                w_data_rd;
    logic                w_stat_rd;
    logic [AWIDTH-1:0]   w_wr_ptr;
    logic [AWIDTH-1:0]   w_ptr_inc;
    logic [AWIDTH+WIDTH-1:0] w_ptr_wide;
    logic [WIDTH-1:0]    w_status;

    assign w_ptr_wr  = cs & ~rw & ~addr;
    assign w_data_rd = cs &  rw &  addr;
    assign w_stat_rd = cs &  rw & ~addr;

    // Out-of-range pointer loads land on location 0.
    assign w_wr_ptr  = (data_in[AWIDTH-1:0] > LAST_PTR) ? '0 : data_in[AWIDTH-1:0];
    assign w_ptr_inc = (r_ptr == LAST_PTR) ? '0 : r_ptr + 1'b1;

    // Zero-extend or truncate the pointer into the WIDTH-1 status field.
    assign w_ptr_wide = {{WIDTH{1'b0}}, r_ptr};
    assign w_status   = {(r_state == S_FULL), w_ptr_wide[WIDTH-2:0]};

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_buf_nxt      = r_buf;
        w_data_out_nxt = r_data_out;
        w_src_addr_nxt = r_src_addr;
        w_src_rd_nxt   = 1'b0;
        w_drop_nxt     = r_drop;

        case (r_state)
            S_IDLE: begin
                // A discarded fetch is still in flight: swallow its ack before issuing anew.
                if (r_drop) begin
                    if (src_ack) begin
                        w_drop_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt    = S_FETCH;
                    w_src_rd_nxt   = 1'b1;
                    w_src_addr_nxt = r_ptr;
                end
            end
            S_FETCH: begin
                if (src_ack) begin
                    w_buf_nxt   = src_data;
                    w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_data_rd) begin
            if (r_state == S_FULL) begin
                w_data_out_nxt = r_buf;
                w_ptr_nxt      = w_ptr_inc;
                w_state_nxt    = S_IDLE;
            end else begin
                w_data_out_nxt = '1;
            end
        end

        if (w_stat_rd) begin
            w_data_out_nxt = w_status;
        end

        // A pointer load beats a same-cycle ack; only a still-pending ack needs dropping.
        if (w_ptr_wr) begin
            w_ptr_nxt      = w_wr_ptr;
            w_state_nxt    = S_IDLE;
            w_src_rd_nxt   = 1'b0;
            w_src_addr_nxt = r_src_addr;
            w_buf_nxt      = r_buf;
            w_drop_nxt     = ((r_state == S_FETCH) | r_drop) & ~src_ack;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= RST_PTR;
            r_buf      <= '0;
            r_data_out <= '0;
            r_src_addr <= RST_PTR;
            r_src_rd   <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_buf      <= w_buf_nxt;
            r_data_out <= w_data_out_nxt;
            r_src_addr <= w_src_addr_nxt;
            r_src_rd   <= w_src_rd_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    assign data_out    = r_data_out;
    assign src_addr    = r_src_addr;
    assign src_rd      = r_src_rd;
    assign valid       = (r_state == S_FULL);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_reg_readback_port.sv
// Bench for reg_readback_port: directed bus accesses, a behavioural register source,
// and a read-data scoreboard fed by the driver and drained by a monitor.
module tb_reg_readback_port;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cs = 1'b0;
    logic       rw = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic [5:0] src_addr;
    logic       src_rd;
    logic       src_ack;
    logic [7:0] src_data;
    logic       valid;
    logic [1:0] dbg_state;

    logic       src_auto = 1'b1;
    int         ack_delay = 1;
    logic       auto_ack = 1'b0;
    logic [7:0] auto_data = 8'h00;
    logic       man_ack = 1'b0;
    logic [7:0] man_data = 8'h00;
    int         fetch_cnt = 0;
    logic [5:0] last_fetch = 6'h3f;
    logic [5:0] fetch_a;

    logic [7:0] exp_q[$];
    int         checks = 0;
    int         failures = 0;

    assign src_ack  = src_auto ? auto_ack  : man_ack;
    assign src_data = src_auto ? auto_data : man_data;

    reg_readback_port #(
        .WIDTH(8), .AWIDTH(6), .DEPTH(48), .RESET_PTR(0)
    ) dut (
        .clock(clock), .reset(reset), .cs(cs), .rw(rw), .addr(addr),
        .data_in(data_in), .data_out(data_out), .src_addr(src_addr),
        .src_rd(src_rd), .src_ack(src_ack), .src_data(src_data),
        .valid(valid), .o_dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] src_mem(input logic [5:0] a);
        return (a == 6'd0) ? 8'h5A : {2'b00, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All stimulus lives at posedge+1; the DUT samples on the falling edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bus(input logic a, input logic r, input logic [7:0] d);
        cs = 1'b1; addr = a; rw = r; data_in = d;
        tick();
        cs = 1'b0; rw = 1'b0; addr = 1'b0; data_in = 8'h00;
    endtask

    task automatic wr_ptr(input logic [7:0] p);
        bus(1'b0, 1'b0, p);
    endtask

    task automatic rd_data(input logic [7:0] e);
        exp_q.push_back(e);
        bus(1'b1, 1'b1, 8'h00);
    endtask

    task automatic rd_status(input logic [7:0] e);
        exp_q.push_back(e);
        bus(1'b0, 1'b1, 8'h00);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50 && !valid; i++) tick();
        check(name, valid, 1);
    endtask

    // Behavioural register source: answers each fetch request after ack_delay clocks.
    always begin
        @(posedge clock);
        if (src_auto && src_rd && !reset) begin
            fetch_a    = src_addr;
            fetch_cnt  = fetch_cnt + 1;
            last_fetch = fetch_a;
            repeat (ack_delay - 1) @(posedge clock);
            #1;
            auto_data = src_mem(fetch_a);
            auto_ack  = 1'b1;
            @(posedge clock);
            #1;
            auto_ack  = 1'b0;
            auto_data = 8'h00;
        end
    end

    // Read result is registered on the falling edge inside the cs cycle.
    always @(posedge clock) begin
        if (!reset && cs && rw) begin
            if (exp_q.size() == 0) begin
                check("rd_no_expect", exp_q.size(), 1);
            end else begin
                check("rd_data_out", data_out, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Test 1: reset values, first auto fetch, status
        repeat (3) tick();
        check("rst_data_out", data_out, 8'h00);
        check("rst_src_rd", src_rd, 0);
        check("rst_valid", valid, 0);
        check("rst_src_addr", src_addr, 6'd0);
        check("rst_state", dbg_state, 2'd0);
        reset = 1'b0;
        tick();
        check("t1_src_rd", src_rd, 1);
        check("t1_src_addr", src_addr, 6'd0);
        check("t1_valid_early", valid, 0);
        tick();
        check("t1_valid", valid, 1);
        check("t1_src_rd_pulse", src_rd, 0);
        check("t1_fetch_cnt", fetch_cnt, 1);
        rd_status(8'h80);

        // Test 2: streaming reads from 0x10
        wr_ptr(8'h10);
        check("t2_valid_clr", valid, 0);
        for (int k = 0; k < 4; k++) begin
            wait_valid("t2_wait");
            rd_data(8'h10 + 8'(k));
        end
        rd_status(8'h14);

        // Test 3: wrap from DEPTH-1 and out-of-range pointer load
        wr_ptr(8'd47);
        wait_valid("t3_wait47");
        rd_data(8'h2F);
        rd_status(8'h00);
        wait_valid("t3_wait0");
        check("t3_wrap_fetch", last_fetch, 6'd0);
        rd_data(8'h5A);
        wr_ptr(8'd50);
        rd_status(8'h00);
        wait_valid("t3_wait50");
        rd_status(8'h80);

        // Test 4: underrun while fetching
        ack_delay = 5;
        wr_ptr(8'h03);
        tick();
        rd_data(8'hFF);
        rd_status(8'h03);
        wait_valid("t4_wait");
        rd_data(8'h03);
        tick();
        tick();
        check("t4_hold", data_out, 8'h03);
        ack_delay = 1;
        wait_valid("t4_settle");

        // Test 5: pointer load during fetch drops the late ack
        src_auto = 1'b0;
        wr_ptr(8'h05);
        tick();
        check("t5_src_rd", src_rd, 1);
        check("t5_src_addr", src_addr, 6'h05);
        wr_ptr(8'h20);
        tick();
        tick();
        check("t5_no_refetch", src_rd, 0);
        check("t5_state_idle", dbg_state, 2'd0);
        man_ack = 1'b1; man_data = 8'hAA;
        tick();
        man_ack = 1'b0;
        check("t5_drop_valid", valid, 0);
        tick();
        check("t5_refetch", src_rd, 1);
        check("t5_refetch_addr", src_addr, 6'h20);
        man_ack = 1'b1; man_data = src_mem(6'h20);
        tick();
        man_ack = 1'b0;
        check("t5_valid", valid, 1);
        rd_data(8'h20);

        // Test 6: reset mid-fetch, stray ack ignored
        tick();
        check("t6_in_fetch", dbg_state, 2'd1);
        reset = 1'b1;
        tick();
        check("t6_rst_data_out", data_out, 8'h00);
        check("t6_rst_valid", valid, 0);
        check("t6_rst_src_addr", src_addr, 6'd0);
        check("t6_rst_state", dbg_state, 2'd0);
        reset = 1'b0;
        man_ack = 1'b1; man_data = 8'hEE;
        tick();
        man_ack = 1'b0;
        check("t6_src_rd", src_rd, 1);
        check("t6_src_addr", src_addr, 6'd0);
        check("t6_stray_ignored", dbg_state, 2'd1);
        man_ack = 1'b1; man_data = src_mem(6'd0);
        tick();
        man_ack = 1'b0;
        check("t6_valid", valid, 1);
        rd_data(8'h5A);

        tick();
        tick();
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
